xalu: RTL and testbench

XALU -- requirements
Module: xalu

---
 rtl/xalu_pkg.sv | 24 ++
 rtl/xalu.sv | 106 ++++++++++
 tb/tb_xalu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the extended ALU: XOp encodings, request width and
// multi-cycle latencies, kept here so the stall unit and decoder agree on them.
package xalu_pkg;

    // Width of the Start request field; a value of 1 means "request".
    localparam int start_size = 1;

    // Counter width; must hold the longest latency.
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
    localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

    typedef enum logic [2:0] {
        XOP_NONE  = 3'd0,
        XOP_MULT  = 3'd1,
        XOP_MULTU = 3'd2,
        XOP_DIV   = 3'd3,
        XOP_DIVU  = 3'd4,
        XOP_MTHI  = 3'd5,
        XOP_MTLO  = 3'd6
    } xop_e;

endpackage

// File: rtl/xalu.sv
// Extended ALU: mult/multu/div/divu with fixed modelled latency, plus mthi/mtlo.
// The result is computed combinationally at the request edge and parked in
// pending registers; HI/LO are committed only when the latency counter expires.
module xalu
    import xalu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           A,
    input  logic [31:0]           B,
    input  logic [start_size-1:0] Start,
    input  logic [2:0]            XOp,
    output logic                  Busy,
    output logic [31:0]           HI,
    output logic [31:0]           LO
);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_wr;   // cleared for divide-by-zero so HI/LO stay put

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        req;

    assign Busy = (cnt != '0);
    assign req  = (Start == start_size'(1)) && !Busy;

    // Products for both signednesses.
    always_comb begin
        prod_s = $signed(A) * $signed(B);
        prod_u = {32'd0, A} * {32'd0, B};
    end

    // Division on magnitudes: the quotient truncates toward zero and the remainder
    // takes the dividend's sign. Working on magnitudes also makes
    // 0x80000000 / -1 come out as 0x80000000 with no special case.
    always_comb begin
        div_signed = (XOp == XOP_DIV);
        a_neg      = div_signed & A[31];
        b_neg      = div_signed & B[31];
        a_mag      = a_neg ? (32'd0 - A) : A;
        b_mag      = b_neg ? (32'd0 - B) : B;
        q_mag      = '0;
        r_mag      = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Counter, pending result and architectural HI/LO; requests while busy are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (Busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (req) begin
            case (XOp)
                XOP_MULT: begin
                    pend_hi <= prod_s[63:32];
                    pend_lo <= prod_s[31:0];
                    pend_wr <= 1'b1;
                    cnt     <= MULT_CYCLES;
                end
                XOP_MULTU: begin
                    pend_hi <= prod_u[63:32];
                    pend_lo <= prod_u[31:0];
                    pend_wr <= 1'b1;
                    cnt     <= MULT_CYCLES;
                end
                XOP_DIV, XOP_DIVU: begin
                    pend_hi <= rem;
                    pend_lo <= quot;
                    pend_wr <= (B != '0);
                    cnt     <= DIV_CYCLES;
                end
                XOP_MTHI: HI <= A;
                XOP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xalu.sv
// Self-checking bench for xalu: a vector table driven through a scoreboard queue,
// plus hand sequences for overlap, reset abort and reset-vs-start priority.
module tb_xalu;
    import xalu_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [31:0]           A, B;
    logic [start_size-1:0] Start;
    logic [2:0]            XOp;
    logic                  Busy;
    logic [31:0]           HI, LO;

    xalu dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Start (Start),
        .XOp   (XOp),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  xop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_busy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb_q[$];
    vec_t vecs[15];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, count Busy cycles (HI/LO must hold meanwhile), then
    // compare the committed result against the scoreboard.
    task automatic run_op(input vec_t v, input int idx);
        logic [31:0] old_hi, old_lo;
        res_t        r;
        int          nb;
        old_hi = HI;
        old_lo = LO;
        sb_q.push_back('{hi: v.exp_hi, lo: v.exp_lo});
        @(negedge clk);
        A = v.a; B = v.b; XOp = v.xop; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        nb = 0;
        while (Busy && nb < 20) begin
            nb++;
            check($sformatf("v%0d_hold_hi", idx), HI, old_hi);
            check($sformatf("v%0d_hold_lo", idx), LO, old_lo);
            @(posedge clk); #1;
        end
        check($sformatf("v%0d_busy_cycles", idx), 32'(nb), 32'(v.exp_busy));
        r = sb_q.pop_front();
        check($sformatf("v%0d_hi", idx), HI, r.hi);
        check($sformatf("v%0d_lo", idx), LO, r.lo);
    endtask

    initial begin
        int nb;
        vecs[0]  = '{XOP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{XOP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{XOP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{XOP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        10};
        vecs[4]  = '{XOP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'd3,        0};
        vecs[5]  = '{XOP_MTLO,  32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[6]  = '{XOP_MTHI,  32'h5,        32'd0,        32'h5,        32'h9ABCDEF0, 0};
        vecs[7]  = '{XOP_DIVU,  32'd99,       32'd0,        32'h5,        32'h9ABCDEF0, 10};
        vecs[8]  = '{XOP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        vecs[9]  = '{XOP_NONE,  32'd1,        32'd1,        32'd0,        32'h80000000, 0};
        vecs[10] = '{3'd7,      32'd1,        32'd1,        32'd0,        32'h80000000, 0};
        vecs[11] = '{XOP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[12] = '{XOP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10};
        vecs[13] = '{XOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[14] = '{XOP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        reset = 1'b1; Start = 1'b0; XOp = 3'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_op(vecs[i], i);

        // Second request (div at cycle 2) and an mthi at cycle 3 arrive while busy.
        nb = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            Start = (k == 0 || k == 2 || k == 3) ? 1'b1 : 1'b0;
            XOp   = (k == 0) ? XOP_MULT : ((k == 2) ? XOP_DIV : XOP_MTHI);
            A     = (k == 0) ? 32'd3 : 32'd1000;
            B     = (k == 0) ? 32'd4 : 32'd3;
            @(posedge clk); #1;
            if (Busy) nb++;
        end
        Start = 1'b0;
        check("overlap_busy_cycles", 32'(nb), 32'd5);
        check("overlap_hi", HI, 32'd0);
        check("overlap_lo", LO, 32'd12);

        // Reset at cycle 4 aborts a running div.
        nb = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            Start = (k == 0) ? 1'b1 : 1'b0;
            XOp   = XOP_DIV; A = 32'd100; B = 32'd7;
            reset = (k == 4) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (k == 4) begin
                check("abort_busy", 32'(Busy), 32'd0);
                check("abort_hi", HI, 32'd0);
                check("abort_lo", LO, 32'd0);
            end
            if (k >= 4 && Busy) nb++;
        end
        check("abort_no_busy_after", 32'(nb), 32'd0);
        check("abort_hi_final", HI, 32'd0);
        check("abort_lo_final", LO, 32'd0);

        // Reset wins over a simultaneous Start (mtlo and mult).
        @(negedge clk);
        reset = 1'b1; Start = 1'b1; XOp = XOP_MTLO; A = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("rst_prio_lo", LO, 32'd0);
        @(negedge clk);
        XOp = XOP_MULT; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0; Start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("rst_prio_hi_final", HI, 32'd0);
        check("rst_prio_lo_final", LO, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
